uart_byte_fifo: RTL and testbench

//  Byte FIFO between the UART receiver output and the UART transmitter input.

---
 rtl/uart_byte_fifo_if.sv | 59 +++++
 rtl/uart_byte_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_byte_fifo.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo_if
//   Interface that carries the handshake and status signals of uart_byte_fifo.
//   The write side is fed by the UART RX byte-valid strobe. The read side is a
//   valid/ready stream into the UART TX.
//
//   Signals (the slave side is the FIFO):
//     wr_valid      1     one-cycle write strobe from RX
//     wr_data       DW    write byte
//     rd_valid      1     head entry present
//     rd_data       DW    head byte
//     rd_ready      1     TX accepts the head byte
//     full          1     occupancy == DEPTH
//     empty         1     occupancy == 0
//     fill          AW+1  occupancy, 0..DEPTH
//     overflow      1     sticky flag: a write was dropped
//     clr_overflow  1     synchronous clear of overflow
//     almost_full   1     only when UART_FIFO_ALMOST_FULL_EN is defined
//
//   Optional feature macro: UART_FIFO_ALMOST_FULL_EN
// -----------------------------------------------------------------------------
interface uart_byte_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          full;
    logic          empty;
    logic [AW:0]   fill;
    logic          overflow;
    logic          clr_overflow;
`ifdef UART_FIFO_ALMOST_FULL_EN
    logic          almost_full;

    modport master (
        output wr_valid, wr_data, rd_ready, clr_overflow,
        input  rd_valid, rd_data, full, empty, fill, overflow, almost_full
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready, clr_overflow,
        output rd_valid, rd_data, full, empty, fill, overflow, almost_full
    );
`else
    modport master (
        output wr_valid, wr_data, rd_ready, clr_overflow,
        input  rd_valid, rd_data, full, empty, fill, overflow
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready, clr_overflow,
        output rd_valid, rd_data, full, empty, fill, overflow
    );
`endif
endinterface : uart_byte_fifo_if

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
//   Byte FIFO that sits between the UART receiver and the UART transmitter. It
//   absorbs RX bursts while TX is busy, and it turns the single-cycle RX
//   byte-valid pulses into a valid/ready stream for TX. RX cannot be stalled,
//   so a byte that arrives while the FIFO is full is dropped, and the sticky
//   overflow flag is set.
//
//   Parameters:
//     DW  data width (UART payload width)
//     AW  address width, DEPTH = 2**AW
//     HW  almost-full margin in entries (only with UART_FIFO_ALMOST_FULL_EN)
//
//   Ports:
//     clk      system clock, rising edge
//     i_reset  asynchronous reset, active-low
//     bus      uart_byte_fifo_if.slave (write strobe, read stream, status)
//
//   Optional feature macro: UART_FIFO_ALMOST_FULL_EN adds bus.almost_full,
//   which is registered and is 1 when fill >= DEPTH-HW.
//
//   All outputs are registered except rd_data, which reads the head entry
//   combinationally. There is no fall-through: a byte written at edge N is
//   first visible after edge N.
// -----------------------------------------------------------------------------
module uart_byte_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
`ifdef UART_FIFO_ALMOST_FULL_EN
    ,
    parameter int HW = 2
`endif
) (
    input  logic              clk,
    input  logic              i_reset,
    uart_byte_fifo_if.slave   bus
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
`ifdef UART_FIFO_ALMOST_FULL_EN
    localparam logic [AW:0] AF_LEVEL = (AW + 1)'(DEPTH - HW);
`endif

    logic [DW-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit. Occupancy is kept in its own register,
    // so full and empty can be registered directly from its next value.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fill_q;
    logic [AW:0] fill_nxt;
    logic        full_q;
    logic        empty_q;
    logic        overflow_q;
    logic        overflow_nxt;

    logic push;
    logic pop;
    logic drop;

    // A pop needs a present head entry. If a pop happens in the same cycle,
    // a write into a full FIFO is still accepted.
    assign pop  = ~empty_q & bus.rd_ready;
    assign push = bus.wr_valid & (~full_q | pop);
    assign drop = bus.wr_valid & full_q & ~pop;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        fill_nxt = fill_q;
        case ({push, pop})
            2'b10:   fill_nxt = fill_q + 1'b1;
            2'b01:   fill_nxt = fill_q - 1'b1;
            default: fill_nxt = fill_q;
        endcase
    end

    // A drop takes priority over a clear in the same cycle.
    always_comb begin
        overflow_nxt = overflow_q;
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples values from before the edge.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_q     <= fill_nxt;
            full_q     <= (fill_nxt == DEPTH_V);
            empty_q    <= (fill_nxt == '0);
            overflow_q <= overflow_nxt;
        end
    end

    // NOTE: the storage array has no reset. Reset clears only the pointers,
    // and a stale entry is never presented as valid, so clearing the array
    // would add reset fan-out with no functional effect.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

`ifdef UART_FIFO_ALMOST_FULL_EN
    logic almost_full_q;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (fill_nxt >= AF_LEVEL);
        end
    end

    assign bus.almost_full = almost_full_q;
`endif

    assign bus.rd_data  = mem[rd_ptr[AW-1:0]];
    assign bus.rd_valid = ~empty_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.fill     = fill_q;
    assign bus.overflow = overflow_q;

endmodule : uart_byte_fifo

// File: tb/tb_uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_fifo
//   Directed testbench for uart_byte_fifo. Inputs are driven 1 time unit after
//   the rising edge. Outputs are sampled at the same point, so they reflect the
//   state left by the preceding edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_byte_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic i_reset;

    int vectors;
    int miscompares;

    uart_byte_fifo_if #(.DW(DW), .AW(AW)) bus ();

    uart_byte_fifo #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid     = 1'b0;
        bus.wr_data      = '0;
        bus.rd_ready     = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    task automatic write_byte(input logic [DW-1:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
    endtask

    task automatic apply_reset();
        i_reset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        i_reset = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        i_reset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        i_reset = 1'b1;
        tick();
        vectors++;
        if (bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_empty: got %b expected 1", bus.empty);
        end
        vectors++;
        if (bus.full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_full: got %b expected 0", bus.full);
        end
        vectors++;
        if (bus.fill !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_fill: got %0d expected 0", bus.fill);
        end
        vectors++;
        if (bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid);
        end
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overflow: got %b expected 0", bus.overflow);
        end
`ifdef UART_FIFO_ALMOST_FULL_EN
        vectors++;
        if (bus.almost_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_almost_full: got %b expected 0", bus.almost_full);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_order();
        logic [DW-1:0] exp_bytes [3];
        exp_bytes[0] = 8'h41;
        exp_bytes[1] = 8'h42;
        exp_bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) write_byte(exp_bytes[i]);
        vectors++;
        if (bus.fill !== 5'd3) begin
            miscompares++;
            $display("FAIL basic_fill3: got %0d expected 3", bus.fill);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_bytes[i]) begin
                miscompares++;
                $display("FAIL basic_read%0d: got valid=%b data=%02h expected valid=1 data=%02h",
                         i, bus.rd_valid, bus.rd_data, exp_bytes[i]);
            end
            pop_one();
        end
        vectors++;
        if (bus.empty !== 1'b1 || bus.fill !== 5'd0) begin
            miscompares++;
            $display("FAIL basic_drained: got empty=%b fill=%0d expected empty=1 fill=0",
                     bus.empty, bus.fill);
        end

        // A ready request while the FIFO is empty must not move anything.
        pop_one();
        vectors++;
        if (bus.empty !== 1'b1 || bus.fill !== 5'd0) begin
            miscompares++;
            $display("FAIL ready_when_empty: got empty=%b fill=%0d expected empty=1 fill=0",
                     bus.empty, bus.fill);
        end

        // No fall-through: write into an empty FIFO with ready high.
        bus.rd_ready = 1'b1;
        write_byte(8'h5A);
        vectors++;
        if (bus.fill !== 5'd1 || bus.rd_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL no_fallthrough: got fill=%0d data=%02h expected fill=1 data=5a",
                     bus.fill, bus.rd_data);
        end
        tick();
        bus.rd_ready = 1'b0;
        vectors++;
        if (bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL no_fallthrough_pop: got empty=%b expected 1", bus.empty);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        vectors++;
        if (bus.full !== 1'b1 || bus.fill !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_full: got full=%b fill=%0d expected full=1 fill=16",
                     bus.full, bus.fill);
        end
        write_byte(8'hAA);
        vectors++;
        if (bus.overflow !== 1'b1 || bus.fill !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_drop: got overflow=%b fill=%0d expected overflow=1 fill=16",
                     bus.overflow, bus.fill);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (bus.rd_data !== 8'(i) || bus.overflow !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_drain%0d: got data=%02h overflow=%b expected data=%02h overflow=1",
                         i, bus.rd_data, bus.overflow, 8'(i));
            end
            pop_one();
        end
        vectors++;
        if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: got empty=%b overflow=%b expected empty=1 overflow=1",
                     bus.empty, bus.overflow);
        end
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b expected 0", bus.overflow);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h10 + i));

        // Drop and clear in the same cycle: the drop wins.
        bus.clr_overflow = 1'b1;
        write_byte(8'hAA);
        bus.clr_overflow = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_beats_clear: got %b expected 1", bus.overflow);
        end
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;

        // Push 0x55 and pop 0x10 in the same cycle on a full FIFO.
        vectors++;
        if (bus.rd_data !== 8'h10) begin
            miscompares++;
            $display("FAIL fpp_head: got %02h expected 10", bus.rd_data);
        end
        bus.rd_ready = 1'b1;
        write_byte(8'h55);
        bus.rd_ready = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0 || bus.fill !== 5'd16 || bus.full !== 1'b1) begin
            miscompares++;
            $display("FAIL fpp_state: got overflow=%b fill=%0d full=%b expected overflow=0 fill=16 full=1",
                     bus.overflow, bus.fill, bus.full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] exp_b;
            exp_b = (i == DEPTH - 1) ? 8'h55 : 8'(8'h11 + i);
            vectors++;
            if (bus.rd_data !== exp_b) begin
                miscompares++;
                $display("FAIL fpp_drain%0d: got %02h expected %02h", i, bus.rd_data, exp_b);
            end
            pop_one();
        end
        vectors++;
        if (bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fpp_empty: got %b expected 1", bus.empty);
        end
    endtask

    // ------------------------------------------------------------------
    // Random traffic against a queue model. It runs long enough to take both
    // pointers round the wrap bit several times.
    task automatic test_random_wrap();
        logic [DW-1:0] model_q [$];
        logic          model_ovf;
        logic          wv;
        logic          rr;
        logic [DW-1:0] wd;
        logic          m_pop;
        logic          m_push;
        logic          m_full;
        int            total_pushes;

        model_q.delete();
        model_ovf    = 1'b0;
        total_pushes = 0;
        for (int c = 0; c < 240; c++) begin
            if (c < 120) begin
                wv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 1) != 0);
            end else begin
                wv = ($urandom_range(0, 1) != 0);
                rr = ($urandom_range(0, 3) != 0);
            end
            wd = 8'($urandom_range(0, 255));

            vectors++;
            if (bus.rd_valid !== (model_q.size() != 0)) begin
                miscompares++;
                $display("FAIL rnd_valid c%0d: got %b expected %b", c, bus.rd_valid, model_q.size() != 0);
            end
            if (model_q.size() != 0) begin
                vectors++;
                if (bus.rd_data !== model_q[0]) begin
                    miscompares++;
                    $display("FAIL rnd_data c%0d: got %02h expected %02h", c, bus.rd_data, model_q[0]);
                end
            end

            m_full = (model_q.size() == DEPTH);
            m_pop  = (model_q.size() != 0) && rr;
            m_push = wv && (!m_full || m_pop);
            if (wv && m_full && !m_pop) model_ovf = 1'b1;
            if (m_pop) void'(model_q.pop_front());
            if (m_push) begin
                model_q.push_back(wd);
                total_pushes++;
            end

            bus.wr_valid = wv;
            bus.wr_data  = wd;
            bus.rd_ready = rr;
            tick();
            idle_inputs();

            vectors++;
            if (bus.fill !== 5'(model_q.size()) || bus.overflow !== model_ovf) begin
                miscompares++;
                $display("FAIL rnd_fill c%0d: got fill=%0d ovf=%b expected fill=%0d ovf=%b",
                         c, bus.fill, bus.overflow, model_q.size(), model_ovf);
            end
        end
        vectors++;
        if (total_pushes <= 2 * 2 * DEPTH) begin
            miscompares++;
            $display("FAIL rnd_laps: got %0d pushes expected more than %0d", total_pushes, 4 * DEPTH);
        end
    endtask

    // ------------------------------------------------------------------
`ifdef UART_FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        apply_reset();
        for (int i = 0; i < 13; i++) write_byte(8'(i));
        vectors++;
        if (bus.almost_full !== 1'b0 || bus.fill !== 5'd13) begin
            miscompares++;
            $display("FAIL af_13: got af=%b fill=%0d expected af=0 fill=13", bus.almost_full, bus.fill);
        end
        write_byte(8'hEE);
        vectors++;
        if (bus.almost_full !== 1'b1) begin
            miscompares++;
            $display("FAIL af_14: got %b expected 1", bus.almost_full);
        end
        pop_one();
        vectors++;
        if (bus.almost_full !== 1'b0) begin
            miscompares++;
            $display("FAIL af_pop13: got %b expected 0", bus.almost_full);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    // Reset asserted between edges must clear state without a clock edge.
    task automatic test_async_reset();
        write_byte(8'h01);
        write_byte(8'h02);
        #2;
        i_reset = 1'b0;
        #1;
        vectors++;
        if (bus.fill !== 5'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got fill=%0d empty=%b valid=%b expected fill=0 empty=1 valid=0",
                     bus.fill, bus.empty, bus.rd_valid);
        end
        tick();
        i_reset = 1'b1;
        tick();
        vectors++;
        if (bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_release: got empty=%b expected 1", bus.empty);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_order();
        test_overflow();
        test_full_push_pop();
        test_random_wrap();
`ifdef UART_FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_byte_fifo
